bnn_resp_encoder: RTL and testbench
===================================

# bnn_resp_encoder

Response-side counterpart of the BNN command decoder. It captures each BNN classification result, together with the input, weight and bias fields that produced it, and serializes them as a checksummed byte frame. The frame goes onto an 8-bit valid/ready stream that feeds the SPI transmit path back to the host. A one-deep pending slot absorbs a result that arrives while a frame is still being sent.

## Interface
Parameters:
- HDR_BYTE, 8'hA5, frame header value.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- res_valid  in  1  single-cycle strobe; a new result is present.
- res_data  in  4  BNN result.
- cfg_in  in  4  BNN input field used for this result.
- cfg_w  in  16  BNN weight field.
- cfg_b  in  16  BNN bias field.
- tx_data  out  8  current frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts the byte.
- busy  out  1  a frame is in flight or a result is pending.
- drop_cnt  out  DROP_W  count of discarded results; saturates at all-ones.

## Operation
- Frame order with echo enabled: HDR, RES={seq[3:0],res_data}, IN={4'h0,cfg_in}, W_HI, W_LO, B_HI, B_LO, CHK. That is 8 bytes.
- CHK is the XOR of every byte from RES through the byte before CHK. HDR is excluded.
- seq is a 4-bit counter that resets to 0. It is stamped into RES when a frame is loaded, then increments; 15 wraps to 0.
- FSM states: IDLE, HDR, RES, IN, WHI, WLO, BHI, BLO, CHK.
  - IDLE -> HDR when a result is loaded.
  - Each byte state advances only on a tx_valid && tx_ready handshake.
  - CHK -> HDR if a result is available (pending, or arriving that cycle); otherwise CHK -> IDLE.
- Capture rules for res_valid, applied in every cycle:
  - IDLE: the result loads directly into the active frame.
  - Frame active, pending slot empty: the result goes to the pending slot.
  - Frame active, pending slot full: the result is dropped and drop_cnt increments, saturating.
  - CHK handshake in the same cycle as res_valid: the pending result, if any, becomes the active frame and the new result fills the pending slot. Nothing is dropped.
- All captured fields are registered at capture time. Later changes on cfg_* or res_data do not affect a frame already captured.
- busy = (state != IDLE) || pending_full.

## Timing
- Reset values: tx_data=8'h00, tx_valid=0, busy=0, drop_cnt=0, seq=0, pending slot empty, state IDLE. An rst_n low sampled mid-frame aborts the frame immediately, with no partial CHK, and clears all of these.
- Latency: res_valid in IDLE at edge N gives tx_valid=1 and tx_data=HDR_BYTE after edge N+1.
- Stream rules:
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops mid-frame.
  - tx_ready is ignored while tx_valid=0.
- Throughput is one byte per cycle when tx_ready is held high.
- Back-to-back frames have zero bubble: the next HDR is presented the cycle after the CHK handshake.
- The checksum accumulator clears on frame load and updates on each handshake from RES through the last echo byte.

## Configuration
- BNN_RESP_ECHO_EN defined: full 8-byte frame as described above.
- BNN_RESP_ECHO_EN undefined:
  - Frame is HDR, RES, CHK (3 bytes), with CHK = RES.
  - States IN through BLO and the cfg capture registers are not compiled; the cfg_* ports remain but are unused.
  - seq, pending slot and drop behaviour are unchanged.

## Structure
- Shared package bnn_resp_pkg holds:
  - the state enum typedef;
  - the frame-length constants (8 and 3);
  - the default header constant 8'hA5;
  - a packed struct for a captured result {res, in, w, b}.
- One sub-module is natural: bnn_resp_slot, a one-entry holding register with load/take/full. It is instantiated once for the pending slot. The FSM, sequence counter and checksum logic stay in the top module.

## Test plan
- Echo on, tx_ready=1, one strobe with res=4'h9, in=4'h3, w=16'hBEEF, b=16'h1234 -> bytes A5,09,03,BE,EF,12,34,7D on consecutive cycles; busy falls after the CHK byte.
- Echo off, same stimulus -> bytes A5,09,09; the next strobe with res=4'h9 -> A5,19,19 (seq=1).
- tx_ready toggled 1/0 every cycle -> byte sequence unchanged, and tx_data holds during every stall cycle.
- Three strobes 2 cycles apart during frame 0 -> frame 1 follows with zero bubble and seq=1; the third strobe is dropped, drop_cnt=1.
- res_valid coincident with the CHK handshake while the pending slot is full -> the pending result is sent next, the new result is pending, drop_cnt unchanged.
- rst_n low for 1 cycle during the W_LO byte -> next cycle tx_valid=0, seq=0, busy=0, drop_cnt=0; a following strobe produces a clean frame with RES high nibble 0.

Source files
------------

// File: rtl/bnn_resp_pkg.sv
// bnn_resp_pkg: shared types and constants for the BNN response encoder
package bnn_resp_pkg;
  typedef enum logic [3:0] {IDLE, HDR, RES, IN, WHI, WLO, BHI, BLO, CHK} state_t;
  localparam int FRAME_LEN_ECHO = 8;
  localparam int FRAME_LEN_BASE = 3;
  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  typedef struct packed {
    logic [3:0] res;
    logic [3:0] in;
    logic [15:0] w;
    logic [15:0] b;
  } result_t;
endpackage

// File: rtl/bnn_resp_slot.sv
// bnn_resp_slot: one-entry holding register; load wins over take, both together swap in d
module bnn_resp_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
      full <= 1'b0;
    end else begin
      if (load) q <= d;
      if (load || take) full <= load;
    end
  end
endmodule

// File: rtl/bnn_resp_encoder.sv
// bnn_resp_encoder: captures BNN results and streams them as checksummed byte frames
// Ports: res_valid/res_data/cfg_* capture a result; tx_data/tx_valid/tx_ready form the
// byte stream; busy flags a frame in flight or pending; drop_cnt counts discarded results.
// Define BNN_RESP_ECHO_EN for the 8-byte frame echoing cfg fields; otherwise HDR,RES,CHK.
module bnn_resp_encoder
  import bnn_resp_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE = HDR_DEFAULT,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  input  logic [3:0]        res_data,
  input  logic [3:0]        cfg_in,
  input  logic [15:0]       cfg_w,
  input  logic [15:0]       cfg_b,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);
`ifdef BNN_RESP_ECHO_EN
  localparam int SW = $bits(result_t);
`else
  localparam int SW = 4;
`endif
  state_t state, state_nx;
  logic [SW-1:0] new_d, src_d, cur_d, pend_q;
  logic [3:0] seq, cur_seq, cur_res;
  logic [7:0] acc;
  logic idle, hs, chk_done, load_act, pend_full, pend_load, pend_take, drop, acc_en;
`ifdef BNN_RESP_ECHO_EN
  result_t cur_r;
  assign new_d = {res_data, cfg_in, cfg_w, cfg_b};
  assign cur_r = result_t'(cur_d);
  assign cur_res = cur_r.res;
`else
  logic unused_cfg;
  assign new_d = res_data;
  assign cur_res = cur_d;
  assign unused_cfg = ^{cfg_in, cfg_w, cfg_b};
`endif
  assign idle = state == IDLE;
  assign tx_valid = !idle;
  assign hs = tx_valid && tx_ready;
  assign chk_done = state == CHK && hs;
  // At the CHK handshake a pending result takes priority; a same-cycle strobe backfills the slot.
  assign load_act = (res_valid && idle) || (chk_done && (pend_full || res_valid));
  assign pend_take = chk_done && pend_full;
  assign pend_load = res_valid && !idle && (chk_done ? pend_full : !pend_full);
  assign drop = res_valid && !idle && !chk_done && pend_full;
  assign src_d = pend_take ? pend_q : new_d;
  assign acc_en = hs && state inside {RES, IN, WHI, WLO, BHI, BLO};
  assign busy = !idle || pend_full;
  bnn_resp_slot #(.W(SW)) u_pend (
    .clk(clk), .rst_n(rst_n), .load(pend_load), .take(pend_take),
    .d(new_d), .q(pend_q), .full(pend_full)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = load_act ? HDR : IDLE;
      HDR: state_nx = hs ? RES : HDR;
`ifdef BNN_RESP_ECHO_EN
      RES: state_nx = hs ? IN : RES;
      IN: state_nx = hs ? WHI : IN;
      WHI: state_nx = hs ? WLO : WHI;
      WLO: state_nx = hs ? BHI : WLO;
      BHI: state_nx = hs ? BLO : BHI;
      BLO: state_nx = hs ? CHK : BLO;
`else
      RES: state_nx = hs ? CHK : RES;
`endif
      CHK: state_nx = hs ? (load_act ? HDR : IDLE) : CHK;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    tx_data = 8'h00;
    case (state)
      HDR: tx_data = HDR_BYTE;
      RES: tx_data = {cur_seq, cur_res};
`ifdef BNN_RESP_ECHO_EN
      IN: tx_data = {4'h0, cur_r.in};
      WHI: tx_data = cur_r.w[15:8];
      WLO: tx_data = cur_r.w[7:0];
      BHI: tx_data = cur_r.b[15:8];
      BLO: tx_data = cur_r.b[7:0];
`endif
      CHK: tx_data = acc;
      default: tx_data = 8'h00;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      seq <= 4'h0;
      cur_seq <= 4'h0;
      cur_d <= '0;
      acc <= 8'h00;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      if (load_act) begin
        cur_d <= src_d;
        cur_seq <= seq;
        seq <= seq + 4'h1;
        acc <= 8'h00;
      end else if (acc_en) begin
        acc <= acc ^ tx_data;
      end
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bnn_resp_encoder.sv
// tb_bnn_resp_encoder: randomized and directed checks against a frame-queue reference model
module tb_bnn_resp_encoder;
  import bnn_resp_pkg::*;
`ifdef BNN_RESP_ECHO_EN
  localparam int FLEN = FRAME_LEN_ECHO;
  localparam int WLO_LEFT = 4;
  localparam logic [7:0] T1 [FLEN] = '{8'hA5, 8'h09, 8'h03, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h7D};
  localparam logic [7:0] T2_CHK = 8'h6D;
`else
  localparam int FLEN = FRAME_LEN_BASE;
  localparam int WLO_LEFT = 2;
  localparam logic [7:0] T1 [FLEN] = '{8'hA5, 8'h09, 8'h09};
  localparam logic [7:0] T2_CHK = 8'h19;
`endif
  logic clk = 1'b0, rst_n = 1'b0, res_valid = 1'b0, tx_ready = 1'b0;
  logic [3:0] res_data = 4'h0, cfg_in = 4'h0;
  logic [15:0] cfg_w = 16'h0, cfg_b = 16'h0;
  logic [7:0] tx_data, drop_cnt;
  logic tx_valid, busy;
  int n_chk = 0, n_pass = 0;
  logic [7:0] exp_q[$], got_q[$];
  bit m_pend = 1'b0, p_stall = 1'b0;
  logic [39:0] m_pr = '0;
  logic [3:0] m_seq = 4'h0;
  int m_drop = 0;
  logic [7:0] p_data = 8'h00;
  always #5 clk = ~clk;
  bnn_resp_encoder dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data),
    .cfg_in(cfg_in), .cfg_w(cfg_w), .cfg_b(cfg_b), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .drop_cnt(drop_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic build(input logic [39:0] p);
    logic [7:0] f[$];
    logic [7:0] x;
    f.push_back({m_seq, p[39:36]});
`ifdef BNN_RESP_ECHO_EN
    f.push_back({4'h0, p[35:32]});
    f.push_back(p[31:24]);
    f.push_back(p[23:16]);
    f.push_back(p[15:8]);
    f.push_back(p[7:0]);
`endif
    x = 8'h00;
    foreach (f[k]) x ^= f[k];
    exp_q.push_back(HDR_DEFAULT);
    foreach (f[k]) exp_q.push_back(f[k]);
    exp_q.push_back(x);
    m_seq++;
  endtask
  task automatic step(input bit v, input logic [39:0] p, input bit rdy, input bit rn);
    bit idle, hs, last;
    check("tx_valid", tx_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("tx_data", tx_data, exp_q[0]);
    check("busy", busy, exp_q.size() != 0 || m_pend);
    check("drop_cnt", drop_cnt, m_drop);
    if (p_stall) check("hold", tx_data, p_data);
    if (tx_valid && rdy) got_q.push_back(tx_data);
    res_valid = v;
    {res_data, cfg_in, cfg_w, cfg_b} = p;
    tx_ready = rdy;
    rst_n = rn;
    p_stall = rn && exp_q.size() != 0 && !rdy;
    p_data = exp_q.size() != 0 ? exp_q[0] : 8'h00;
    if (!rn) begin
      exp_q.delete();
      m_pend = 1'b0;
      m_seq = 4'h0;
      m_drop = 0;
    end else begin
      idle = exp_q.size() == 0;
      hs = !idle && rdy;
      last = hs && exp_q.size() == 1;
      if (hs) void'(exp_q.pop_front());
      if (v) begin
        if (idle) build(p);
        else if (last) begin
          if (m_pend) begin build(m_pr); m_pr = p; end
          else build(p);
        end else if (!m_pend) begin m_pend = 1'b1; m_pr = p; end
        else if (m_drop < 255) m_drop++;
      end else if (last && m_pend) begin
        build(m_pr);
        m_pend = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [39:0] rnd();
    return {8'($urandom), 32'($urandom)};
  endfunction
  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1;
    step(0, '0, 1, 0);
    check("rst_tx_data", tx_data, 8'h00);
    got_q.delete();
    step(1, 40'h93BEEF1234, 1, 1);
    repeat (10) step(0, '0, 1, 1);
    check("t1_len", got_q.size(), FLEN);
    for (int k = 0; k < FLEN; k++) check($sformatf("t1_b%0d", k), got_q[k], T1[k]);
    got_q.delete();
    step(1, 40'h93BEEF1234, 1, 1);
    repeat (10) step(0, '0, 1, 1);
    check("t2_res", got_q[1], 8'h19);
    check("t2_chk", got_q[FLEN-1], T2_CHK);
    step(1, rnd(), 1, 1);
    for (int k = 0; k < 30; k++) step(0, '0, k % 2 == 0, 1);
    step(1, rnd(), 1, 1);
    step(0, '0, 1, 1);
    step(1, rnd(), 1, 1);
    step(0, '0, 1, 1);
    step(1, rnd(), 1, 1);
    repeat (25) step(0, '0, 1, 1);
`ifdef BNN_RESP_ECHO_EN
    check("t4_drop", drop_cnt, 8'd1);
`endif
    step(1, rnd(), 1, 1);
    step(1, rnd(), 1, 1);
    for (int k = 0; k < 20 && exp_q.size() != 1; k++) step(0, '0, 1, 1);
    d0 = m_drop;
    step(1, rnd(), 1, 1);
    check("t5_drop", drop_cnt, d0);
    check("t5_busy", busy, 1);
    repeat (25) step(0, '0, 1, 1);
    step(1, rnd(), 1, 1);
    step(1, rnd(), 1, 1);
    for (int k = 0; k < 20 && exp_q.size() != WLO_LEFT; k++) step(0, '0, 1, 1);
    step(0, '0, 1, 0);
    check("t6_valid", tx_valid, 0);
    check("t6_busy", busy, 0);
    got_q.delete();
    step(1, 40'h5A12345678, 1, 1);
    repeat (10) step(0, '0, 1, 1);
    check("t6_hdr", got_q[0], 8'hA5);
    check("t6_res", got_q[1], 8'h05);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) == 0, rnd(), $urandom_range(0, 3) != 0, $urandom_range(0, 499) != 0);
    step(0, '0, 1, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
